c2h_stream_packer: RTL and testbench

//  Store-and-forward stage directly downstream of the C2H traffic generator.
//  - Buffers each generated packet whole and counts its byte length.
//  - Re-emits the packet on the QDMA C2H AXI-Stream with ctrl_len, qid and mty known at the first beat.
//  - Issues one completion (CMPT) entry per packet sent.

---
 rtl/c2h_stream_packer.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_c2h_stream_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_stream_packer.sv
// c2h_stream_packer: store-and-forward packer feeding the QDMA C2H AXI-Stream plus CMPT.
// Latency: last ingress beat accepted at edge N -> first C2H beat presented for handshake at edge N+2.
// Backpressure: s_ready drops on a full data or descriptor FIFO; egress holds beats on !tready, next packet waits for CMPT.
// Optional build macro: C2H_PACKER_STATS_EN adds saturating packet/byte/truncation counters.

// Generic FIFO, show-ahead read port; pointers carry an extra wrap bit for full/empty.
module c2h_packer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         axi_aclk,
  input  logic         axi_areset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_dat = mem[rptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO without touching storage.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge axi_aclk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end
endmodule

module c2h_stream_packer #(
  parameter int RX_LEN        = 512,
  parameter int RX_BEN        = 64,
  parameter int DATA_DEPTH    = 64,
  parameter int LEN_DEPTH     = 8,
  parameter int MAX_PKT_BYTES = 4096,
  parameter int QID_W         = 11
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [RX_LEN-1:0] s_data,
  input  logic [RX_BEN-1:0] s_ben,
  input  logic              s_last,
  input  logic [QID_W-1:0]  qid,
  output logic              m_axis_c2h_tvalid,
  input  logic              m_axis_c2h_tready,
  output logic [RX_LEN-1:0] m_axis_c2h_tdata,
  output logic              m_axis_c2h_tlast,
  output logic [5:0]        m_axis_c2h_mty,
  output logic [15:0]       m_axis_c2h_ctrl_len,
  output logic [QID_W-1:0]  m_axis_c2h_ctrl_qid,
  output logic              cmpt_valid,
  input  logic              cmpt_ready,
  output logic [15:0]       cmpt_len,
  output logic [15:0]       cmpt_pkt_id,
  output logic              cmpt_trunc
`ifdef C2H_PACKER_STATS_EN
  ,
  output logic [31:0]       stat_pkt_cnt,
  output logic [47:0]       stat_byte_cnt,
  output logic [15:0]       stat_trunc_cnt
`endif
);
  localparam int          BC_W    = $clog2(RX_BEN) + 1;
  localparam int          OFS_W   = $clog2(RX_BEN);
  localparam int          DESC_W  = 16 + QID_W + 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_BYTES);

  typedef enum logic [1:0] {IDLE, SEND, CMPT} state_t;

  // Bytes carried by one beat: full width unless last; an all-zero last mask means full width.
  function automatic logic [BC_W-1:0] beat_bytes(input logic [RX_BEN-1:0] ben);
    logic [BC_W-1:0] n;
    n = '0;
    for (int i = 0; i < RX_BEN; i++) n = n + {{(BC_W-1){1'b0}}, ben[i]};
    if (n == '0) n = BC_W'(RX_BEN);
    return n;
  endfunction

  // ---------------- ingress ----------------
  logic              in_en;
  logic [15:0]       acc;
  logic              trunc_r;
  logic              first_r;
  logic [QID_W-1:0]  qid_r;
  logic [BC_W-1:0]   in_bytes;
  logic [15:0]       acc_sum;
  logic              wr_ok;
  logic              budget_spent;
  logic              beat_acc;
  logic              data_push;
  logic              desc_push;
  logic              desc_trunc;
  logic [15:0]       desc_len;
  logic [QID_W-1:0]  desc_qid;
  logic              data_full;
  logic              data_empty;
  logic              desc_full;
  logic              desc_empty;
  logic [RX_LEN-1:0] data_dout;
  logic [DESC_W-1:0] desc_dout;

  assign in_bytes     = s_last ? beat_bytes(s_ben) : BC_W'(RX_BEN);
  assign acc_sum      = acc + 16'(in_bytes);
  assign wr_ok        = (acc_sum <= MAX_LEN);
  assign budget_spent = (acc >= MAX_LEN);
  // Once the byte budget is used up nothing more is written, so a full data FIFO
  // must not stall the tail: the descriptor that lets egress drain only comes with s_last.
  assign s_ready      = in_en & ~desc_full & (~data_full | budget_spent);
  assign beat_acc     = s_valid & s_ready;
  assign data_push    = beat_acc & wr_ok;
  assign desc_push    = beat_acc & s_last;
  assign desc_trunc   = trunc_r | ~wr_ok;
  assign desc_len     = desc_trunc ? MAX_LEN : acc_sum;
  assign desc_qid     = first_r ? qid : qid_r;

  // Per-packet length accumulation, truncation tracking and first-beat qid capture.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      in_en   <= 1'b0;
      acc     <= '0;
      trunc_r <= 1'b0;
      first_r <= 1'b1;
      qid_r   <= '0;
    end else begin
      in_en <= 1'b1;
      if (beat_acc) begin
        if (s_last) begin
          acc     <= '0;
          trunc_r <= 1'b0;
          first_r <= 1'b1;
        end else begin
          first_r <= 1'b0;
          if (first_r) qid_r <= qid;
          if (wr_ok) acc <= acc_sum;
          else       trunc_r <= 1'b1;
        end
      end
    end
  end

  // ---------------- buffering ----------------
  logic state_send;
  logic data_pop;
  logic desc_pop;

  c2h_packer_fifo #(.W(RX_LEN), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .push       (data_push),
    .push_dat   (s_data),
    .pop        (data_pop),
    .pop_dat    (data_dout),
    .full       (data_full),
    .empty      (data_empty)
  );

  c2h_packer_fifo #(.W(DESC_W), .DEPTH(LEN_DEPTH)) u_desc_fifo (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .push       (desc_push),
    .push_dat   ({desc_len, desc_qid, desc_trunc}),
    .pop        (desc_pop),
    .pop_dat    (desc_dout),
    .full       (desc_full),
    .empty      (desc_empty)
  );

  // ---------------- egress ----------------
  state_t           state;
  state_t           state_nxt;
  logic [15:0]      d_len;
  logic [QID_W-1:0] d_qid;
  logic             d_trunc;
  logic [5:0]       d_mty;
  logic [15:0]      d_beats;
  logic [15:0]      ctrl_len_r;
  logic [QID_W-1:0] ctrl_qid_r;
  logic             hold_trunc;
  logic [5:0]       mty_r;
  logic [15:0]      beats_left;
  logic [15:0]      cmpt_len_r;
  logic             cmpt_trunc_r;
  logic [15:0]      pkt_id;
  logic             last_beat;
  logic             cmpt_hs;

  assign {d_len, d_qid, d_trunc} = desc_dout;
  assign d_mty     = 6'((RX_BEN - int'(d_len[OFS_W-1:0])) % RX_BEN);
  assign d_beats   = (d_len + 16'(RX_BEN - 1)) >> OFS_W;
  assign last_beat = (beats_left == 16'd1);
  assign state_send = (state == SEND);
  assign cmpt_hs   = (state == CMPT) & cmpt_ready;

  // Next state and FIFO pop strobes.
  always_comb begin
    state_nxt = state;
    desc_pop  = 1'b0;
    data_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!desc_empty) begin
          desc_pop  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (m_axis_c2h_tready && !data_empty) begin
          data_pop = 1'b1;
          if (last_beat) state_nxt = CMPT;
        end
      end
      CMPT: begin
        if (cmpt_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) state <= IDLE;
    else            state <= state_nxt;
  end

  // Packet context, beat countdown, completion fields and running packet id.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      ctrl_len_r   <= '0;
      ctrl_qid_r   <= '0;
      hold_trunc   <= 1'b0;
      mty_r        <= '0;
      beats_left   <= '0;
      cmpt_len_r   <= '0;
      cmpt_trunc_r <= 1'b0;
      pkt_id       <= '0;
    end else begin
      if (desc_pop) begin
        ctrl_len_r <= d_len;
        ctrl_qid_r <= d_qid;
        hold_trunc <= d_trunc;
        mty_r      <= d_mty;
        beats_left <= d_beats;
      end
      if (data_pop) begin
        beats_left <= beats_left - 16'd1;
        if (last_beat) begin
          cmpt_len_r   <= ctrl_len_r;
          cmpt_trunc_r <= hold_trunc;
        end
      end
      if (cmpt_hs) pkt_id <= pkt_id + 16'd1;
    end
  end

  assign m_axis_c2h_tvalid   = state_send;
  assign m_axis_c2h_tdata    = state_send ? data_dout : '0;
  assign m_axis_c2h_tlast    = state_send & last_beat;
  assign m_axis_c2h_mty      = m_axis_c2h_tlast ? mty_r : 6'd0;
  assign m_axis_c2h_ctrl_len = ctrl_len_r;
  assign m_axis_c2h_ctrl_qid = ctrl_qid_r;
  assign cmpt_valid          = (state == CMPT);
  assign cmpt_len            = cmpt_len_r;
  assign cmpt_pkt_id         = pkt_id;
  assign cmpt_trunc          = cmpt_trunc_r;

`ifdef C2H_PACKER_STATS_EN
  logic [48:0] byte_sum;
  assign byte_sum = {1'b0, stat_byte_cnt} + 49'(cmpt_len_r);

  // Saturating traffic statistics.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      stat_pkt_cnt   <= '0;
      stat_byte_cnt  <= '0;
      stat_trunc_cnt <= '0;
    end else begin
      if (cmpt_hs) begin
        if (stat_pkt_cnt != '1) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
        stat_byte_cnt <= byte_sum[48] ? '1 : byte_sum[47:0];
      end
      if (desc_push && desc_trunc && (stat_trunc_cnt != '1))
        stat_trunc_cnt <= stat_trunc_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_c2h_stream_packer.sv
// Bench for c2h_stream_packer: directed scenarios plus randomized packets,
// scored against a packet-level model (byte length, truncation budget, beat list).
module tb_c2h_stream_packer;
  localparam int MAXB = 4096;

  logic         axi_aclk;
  logic         axi_areset;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] s_data;
  logic [63:0]  s_ben;
  logic         s_last;
  logic [10:0]  qid;
  logic         m_axis_c2h_tvalid;
  logic         m_axis_c2h_tready;
  logic [511:0] m_axis_c2h_tdata;
  logic         m_axis_c2h_tlast;
  logic [5:0]   m_axis_c2h_mty;
  logic [15:0]  m_axis_c2h_ctrl_len;
  logic [10:0]  m_axis_c2h_ctrl_qid;
  logic         cmpt_valid;
  logic         cmpt_ready;
  logic [15:0]  cmpt_len;
  logic [15:0]  cmpt_pkt_id;
  logic         cmpt_trunc;

  c2h_stream_packer dut (
    .axi_aclk            (axi_aclk),
    .axi_areset          (axi_areset),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .s_data              (s_data),
    .s_ben               (s_ben),
    .s_last              (s_last),
    .qid                 (qid),
    .m_axis_c2h_tvalid   (m_axis_c2h_tvalid),
    .m_axis_c2h_tready   (m_axis_c2h_tready),
    .m_axis_c2h_tdata    (m_axis_c2h_tdata),
    .m_axis_c2h_tlast    (m_axis_c2h_tlast),
    .m_axis_c2h_mty      (m_axis_c2h_mty),
    .m_axis_c2h_ctrl_len (m_axis_c2h_ctrl_len),
    .m_axis_c2h_ctrl_qid (m_axis_c2h_ctrl_qid),
    .cmpt_valid          (cmpt_valid),
    .cmpt_ready          (cmpt_ready),
    .cmpt_len            (cmpt_len),
    .cmpt_pkt_id         (cmpt_pkt_id),
    .cmpt_trunc          (cmpt_trunc)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    int          len;
    bit          trunc;
    logic [10:0] qid;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] exp_beats[$];
  logic [15:0]  exp_pid;
  int           n_chk;
  int           n_pass;
  int           n_fail;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] rnd_beat();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ben_mode for a full last beat: 0 = all ones, 1 = all zeros, 2 = either.
  task automatic send_pkt(input int len, input logic [10:0] q, input int ben_mode);
    int           nb;
    int           lastb;
    int           w;
    logic [511:0] d;
    exp_t         e;
    nb    = (len + 63) / 64;
    lastb = len - 64 * (nb - 1);
    for (int i = 0; i < nb; i++) begin
      d = rnd_beat();
      if (i < MAXB / 64) exp_beats.push_back(d);
      @(negedge axi_aclk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == nb - 1);
      qid     = (i == 0) ? q : 11'($urandom);
      if (i == nb - 1) begin
        if (lastb < 64)        s_ben = (64'd1 << lastb) - 64'd1;
        else if (ben_mode == 0) s_ben = {64{1'b1}};
        else if (ben_mode == 1) s_ben = 64'h0;
        else                    s_ben = ($urandom_range(0, 1) == 1) ? 64'h0 : {64{1'b1}};
      end else begin
        s_ben = {$urandom, $urandom};
      end
      w = 0;
      while (!s_ready && w < 500) begin
        @(negedge axi_aclk);
        w++;
      end
      check("s_ready_wait", 512'(s_ready), 512'(1));
      @(posedge axi_aclk);
    end
    @(negedge axi_aclk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    e.len   = (len > MAXB) ? MAXB : len;
    e.trunc = (len > MAXB);
    e.qid   = q;
    exp_q.push_back(e);
  endtask

  task automatic collect_pkt(input bit rnd, input int hold_in);
    exp_t     e;
    int       nb;
    int       idx;
    int       cyc;
    int       hold;
    bit       done;
    bit       lastx;
    logic [5:0] em;
    hold = hold_in;
    e    = exp_q.pop_front();
    nb   = (e.len + 63) / 64;
    em   = 6'((64 - (e.len % 64)) % 64);
    idx  = 0;
    cyc  = 0;
    done = 1'b0;
    cmpt_ready = (hold == 0);
    while (!done && cyc < 3000) begin
      @(negedge axi_aclk);
      cyc++;
      m_axis_c2h_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (m_axis_c2h_tvalid) begin
        lastx = (idx == nb - 1);
        check("ctrl_len", 512'(m_axis_c2h_ctrl_len), 512'(e.len));
        check("ctrl_qid", 512'(m_axis_c2h_ctrl_qid), 512'(e.qid));
        check("tdata", m_axis_c2h_tdata, exp_beats[0]);
        check("tlast", 512'(m_axis_c2h_tlast), 512'(lastx));
        check("mty", 512'(m_axis_c2h_mty), lastx ? 512'(em) : 512'(0));
        if (m_axis_c2h_tready) begin
          void'(exp_beats.pop_front());
          idx++;
          if (idx == nb) done = 1'b1;
        end
      end
    end
    check("beats_sent", 512'(idx), 512'(nb));
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200 + hold_in) begin
      @(negedge axi_aclk);
      cyc++;
      m_axis_c2h_tready = 1'b0;
      if (cmpt_valid) begin
        if (hold > 0) begin
          check("cmpt_hold_no_start", 512'(m_axis_c2h_tvalid), 512'(0));
          hold--;
          if (hold == 0) cmpt_ready = 1'b1;
        end
        if (hold == 0) begin
          check("cmpt_len", 512'(cmpt_len), 512'(e.len));
          check("cmpt_pkt_id", 512'(cmpt_pkt_id), 512'(exp_pid));
          check("cmpt_trunc", 512'(cmpt_trunc), 512'(e.trunc));
          done = 1'b1;
        end
      end
    end
    check("cmpt_seen", 512'(done), 512'(1));
    exp_pid = exp_pid + 16'd1;
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, 512'(m_axis_c2h_tvalid), 512'(0));
    check({tag, "_tdata"}, m_axis_c2h_tdata, 512'(0));
    check({tag, "_tlast"}, 512'(m_axis_c2h_tlast), 512'(0));
    check({tag, "_mty"}, 512'(m_axis_c2h_mty), 512'(0));
    check({tag, "_ctrl_len"}, 512'(m_axis_c2h_ctrl_len), 512'(0));
    check({tag, "_ctrl_qid"}, 512'(m_axis_c2h_ctrl_qid), 512'(0));
    check({tag, "_cmpt_valid"}, 512'(cmpt_valid), 512'(0));
    check({tag, "_cmpt_len"}, 512'(cmpt_len), 512'(0));
    check({tag, "_cmpt_pkt_id"}, 512'(cmpt_pkt_id), 512'(0));
    check({tag, "_cmpt_trunc"}, 512'(cmpt_trunc), 512'(0));
    check({tag, "_s_ready"}, 512'(s_ready), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; exp_pid = 16'd0;
    axi_areset = 1'b1;
    s_valid = 1'b0; s_data = '0; s_ben = '0; s_last = 1'b0; qid = '0;
    m_axis_c2h_tready = 1'b0; cmpt_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge axi_aclk);
    check_all_zero("reset");
    axi_areset = 1'b0;
    repeat (2) @(negedge axi_aclk);
    check("ready_after_reset", 512'(s_ready), 512'(1));

    // 128B, full last mask; first beat presented two edges after s_last accepted.
    send_pkt(128, 11'h055, 0);
    check("lat_edge_n1", 512'(m_axis_c2h_tvalid), 512'(0));
    @(negedge axi_aclk);
    check("lat_edge_n2", 512'(m_axis_c2h_tvalid), 512'(1));
    collect_pkt(1'b0, 0);

    // 100B: 36-byte last beat -> mty 28.
    send_pkt(100, 11'h123, 0);
    collect_pkt(1'b0, 0);

    // Full last beat signalled with an all-zero mask.
    send_pkt(192, 11'h3a1, 1);
    collect_pkt(1'b0, 0);

    // Eight 512B packets queued behind a stalled egress fill the buffering.
    for (int i = 0; i < 8; i++) send_pkt(512, 11'($urandom), 2);
    check("s_ready_full_512", 512'(s_ready), 512'(0));
    for (int i = 0; i < 8; i++) collect_pkt(1'b1, 0);

    // Nine single-beat packets: one in flight plus eight descriptors.
    for (int i = 0; i < 9; i++) send_pkt(int'($urandom_range(1, 64)), 11'($urandom), 2);
    check("s_ready_desc_full", 512'(s_ready), 512'(0));
    for (int i = 0; i < 9; i++) collect_pkt(1'b1, 0);

    // Truncation and its boundaries.
    send_pkt(5000, 11'h7ff, 2);
    collect_pkt(1'b1, 0);
    send_pkt(64, 11'h001, 0);
    collect_pkt(1'b0, 0);
    send_pkt(4096, 11'h200, 0);
    collect_pkt(1'b1, 0);
    send_pkt(4097, 11'h201, 0);
    collect_pkt(1'b1, 0);

    // CMPT held for 20 cycles blocks the next queued packet.
    send_pkt(64, 11'h0a0, 0);
    send_pkt(64, 11'h0a1, 0);
    collect_pkt(1'b0, 20);
    collect_pkt(1'b0, 0);

    // Randomized lengths, one at a time then in a burst.
    for (int i = 0; i < 12; i++) begin
      send_pkt(int'($urandom_range(1, 700)), 11'($urandom), 2);
      collect_pkt(1'b1, 0);
    end
    for (int i = 0; i < 3; i++) send_pkt(int'($urandom_range(1, 700)), 11'($urandom), 2);
    for (int i = 0; i < 3; i++) collect_pkt(1'b1, 0);

    // Reset in the middle of SEND discards everything and restarts pkt_id.
    send_pkt(128, 11'h0c3, 0);
    @(negedge axi_aclk);
    m_axis_c2h_tready = 1'b1;
    @(negedge axi_aclk);
    m_axis_c2h_tready = 1'b0;
    check("pre_reset_sending", 512'(m_axis_c2h_tvalid), 512'(1));
    axi_areset = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_beats.delete();
    exp_pid = 16'd0;
    @(negedge axi_aclk);
    axi_areset = 1'b0;
    repeat (3) @(negedge axi_aclk);
    check("post_reset_no_resume", 512'(m_axis_c2h_tvalid), 512'(0));
    check("post_reset_no_cmpt", 512'(cmpt_valid), 512'(0));
    send_pkt(64, 11'h044, 0);
    collect_pkt(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
